dram_arb: RTL and testbench
===========================

Name: dram_arb

Overview:
- Two-port arbiter and sequencer in front of the dram_phy block.
- Gives port 0 (lookup engine) and port 1 (update/insert engine) shared access to one RAM: at most one command per cycle.
- Tracks outstanding reads in order and routes each phy read return to the port that issued it.
- Sits between the DB core engines and dram_phy. Its phy-side signals connect straight to dram_phy wr_en/wr_din/addr/rd_en/rd_dout/rd_valid.

Parameters:
- RAM_ADDR, 22, address width in words.
- RAM_DWIDTH, 32, data width.
- MAX_OUTST, 4, maximum reads in flight (tag FIFO depth), power of two, at least 2.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-low (asserted when 0).
- req0_valid / req1_valid  in  1  request present on port 0 / port 1.
- req0_ready / req1_ready  out  1  request accepted this cycle (combinational from grant).
- req0_we / req1_we  in  1  1 = write, 0 = read.
- req0_addr / req1_addr  in  RAM_ADDR  word address.
- req0_wdata / req1_wdata  in  RAM_DWIDTH  write data.
- resp0_valid / resp1_valid  out  1  read data valid, one-cycle pulse.
- resp0_data / resp1_data  out  RAM_DWIDTH  read data.
- phy_wr_en  out  1  to dram_phy wr_en.
- phy_rd_en  out  1  to dram_phy rd_en.
- phy_addr  out  RAM_ADDR  to dram_phy addr.
- phy_wr_din  out  RAM_DWIDTH  to dram_phy wr_din.
- phy_rd_dout  in  RAM_DWIDTH  from dram_phy.
- phy_rd_valid  in  1  from dram_phy.
- busy  out  1  outstanding read count is nonzero.
- err_orphan  out  1  sticky: a phy_rd_valid arrived while no read was outstanding.

Behaviour:
- Reset values:
  - All outputs 0.
  - Tag FIFO empty, count 0.
  - Round-robin pointer favours port 0.
  - err_orphan cleared.
- Eligibility: port p is eligible when reqp_valid=1 AND (reqp_we=1 OR count<MAX_OUTST).
- Grant (round-robin):
  - Eligible favoured port wins, otherwise the other eligible port.
  - At most one grant per cycle. reqp_ready=1 only for the granted port.
  - After a grant to port p, the pointer favours port 1-p. The pointer holds when there is no grant.
- Full FIFO: a read on the favoured port while count==MAX_OUTST is skipped. A write on the other port is still granted that cycle.
- Issue latency: on a grant at edge N, the phy_* outputs are registered and present for exactly the cycle after edge N.
  - Write: phy_wr_en=1, phy_addr, phy_wr_din.
  - Read: phy_rd_en=1, phy_addr; phy_wr_din holds its last value.
  - phy_wr_en and phy_rd_en are never both 1. Both are 0 in cycles with no grant.
- Read tag: on a read grant, the port id is pushed into the tag FIFO in the same edge as the issue register load.
- Return:
  - On phy_rd_valid, pop the head tag t.
  - On the next edge: respt_valid=1 for one cycle, respt_data=phy_rd_dout.
  - respt_data holds between pulses.
- Ordering: responses are delivered strictly in issue order. The phy is in-order, so no reordering.
- Simultaneous push and pop: count unchanged, both take effect.
- A read grant is not allowed by a pop in the same cycle. Eligibility uses the registered count.
- Orphan return: phy_rd_valid with count==0:
  - Data discarded, no resp pulse.
  - err_orphan set to 1 and held until reset.
- Reset mid-operation:
  - FIFO and in-flight tags are discarded.
  - Phy returns arriving after rst deasserts are orphans and set err_orphan.
  - Integration drains dram_phy before asserting reset.
- Address and data pass through unmodified, with no width conversion. Out-of-range addresses are the phy's concern.

Optional Feature:
- Macro DRAM_ARB_STRICT_PRIO_EN.
- Defined: fixed priority, port 0 always wins when eligible; the round-robin pointer is removed.
- Undefined: round-robin as above (default).
- Eligibility rules, full-FIFO skip and all latencies are identical in both modes.

Test Plan:
- Port 0 writes 0x11223344 to 0x000001. Port 1 reads 0x000001 the cycle after the write issues -> resp1_valid pulses with resp1_data=0x11223344; resp0_valid stays 0.
- Both ports request reads every cycle for 8 cycles (port 0 to 0x000002, port 1 to 0x000003, preloaded 0xabcdef12 / 0x01234567) -> phy_rd_en alternates port 0, 1, 0, 1...; responses alternate with the correct data, in order.
- Phy return stalled, port 0 issues 4 reads (MAX_OUTST=4) -> 5th read req0_ready=0 and busy=1. A simultaneous port 1 write to 0x000004 is granted. After one return, port 0's read is accepted.
- phy_rd_valid pulse with no outstanding read -> no resp pulse, err_orphan=1 and stays 1; the next reset clears it.
- Reset asserted with 2 reads in flight -> all outputs 0 during reset; the 2 late returns set err_orphan and produce no resp pulses.
- With DRAM_ARB_STRICT_PRIO_EN defined, both ports continuously valid -> only port 0 granted until req0_valid drops, then port 1 is granted the next cycle.

Source files
------------

// File: rtl/dram_arb.sv
// dram_arb: two-port arbiter/sequencer in front of dram_phy.
//   Port 0 (lookup engine) and port 1 (update/insert engine) share one RAM.
//   At most one command is issued per cycle. Outstanding reads are tracked
//   in an in-order tag FIFO so each phy return is routed to the issuing port.
// Optional build macro: DRAM_ARB_STRICT_PRIO_EN
//   defined   -> fixed priority, port 0 wins whenever it is eligible
//   undefined -> round-robin between the two ports (default)
module dram_arb #(
    parameter int RAM_ADDR   = 22,
    parameter int RAM_DWIDTH = 32,
    parameter int MAX_OUTST  = 4
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic                  req0_we,
    input  logic [RAM_ADDR-1:0]   req0_addr,
    input  logic [RAM_DWIDTH-1:0] req0_wdata,
    output logic                  resp0_valid,
    output logic [RAM_DWIDTH-1:0] resp0_data,

    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic                  req1_we,
    input  logic [RAM_ADDR-1:0]   req1_addr,
    input  logic [RAM_DWIDTH-1:0] req1_wdata,
    output logic                  resp1_valid,
    output logic [RAM_DWIDTH-1:0] resp1_data,

    output logic                  phy_wr_en,
    output logic                  phy_rd_en,
    output logic [RAM_ADDR-1:0]   phy_addr,
    output logic [RAM_DWIDTH-1:0] phy_wr_din,
    input  logic [RAM_DWIDTH-1:0] phy_rd_dout,
    input  logic                  phy_rd_valid,

    output logic                  busy,
    output logic                  err_orphan
);

    localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUTST);

    // Per-port views of the request interface so both ports share one code path.
    logic [1:0]            w_req_valid;
    logic [1:0]            w_req_we;
    logic [RAM_ADDR-1:0]   w_req_addr  [2];
    logic [RAM_DWIDTH-1:0] w_req_wdata [2];
    logic [1:0]            w_elig;
    logic [1:0]            w_ready;

    // Arbitration results.
    logic                  w_favor;
    logic                  w_gnt_any;
    logic                  w_gnt_port;
    logic                  w_sel_we;
    logic [RAM_ADDR-1:0]   w_sel_addr;
    logic [RAM_DWIDTH-1:0] w_sel_wdata;
    logic                  w_has_room;

    // Tag FIFO and return path.
    logic                  r_tag_mem [MAX_OUTST];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_orphan;
    logic                  w_head_tag;

    // Registered issue stage and status.
    logic                  r_phy_wr_en;
    logic                  r_phy_rd_en;
    logic [RAM_ADDR-1:0]   r_phy_addr;
    logic [RAM_DWIDTH-1:0] r_phy_wr_din;
    logic                  r_err_orphan;
    logic                  r_resp_valid [2];
    logic [RAM_DWIDTH-1:0] r_resp_data  [2];

    assign w_req_valid    = {req1_valid, req0_valid};
    assign w_req_we       = {req1_we, req0_we};
    assign w_req_addr[0]  = req0_addr;
    assign w_req_addr[1]  = req1_addr;
    assign w_req_wdata[0] = req0_wdata;
    assign w_req_wdata[1] = req1_wdata;

    // Eligibility looks only at the registered count: a pop landing in the
    // same cycle does not make room for a new read until the next cycle.
    assign w_has_room = (r_count < FULL_CNT);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            localparam logic PORT_ID = 1'(gi);

            assign w_elig[gi]  = w_req_valid[gi] & (w_req_we[gi] | w_has_room);
            assign w_ready[gi] = w_gnt_any & (w_gnt_port == PORT_ID);

            // Deliver a one-cycle response pulse when the popped tag names this port;
            // data holds between pulses.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_resp_valid[gi] <= 1'b0;
                    r_resp_data[gi]  <= '0;
                end else begin
                    r_resp_valid[gi] <= w_pop & (w_head_tag == PORT_ID);
                    if (w_pop && (w_head_tag == PORT_ID)) begin
                        r_resp_data[gi] <= phy_rd_dout;
                    end
                end
            end
        end
    endgenerate

`ifdef DRAM_ARB_STRICT_PRIO_EN
    // Fixed priority: port 0 is always the favoured port.
    assign w_favor = 1'b0;
`else
    logic r_favor;

    assign w_favor = r_favor;

    // Round-robin pointer: after a grant the other port is favoured; holds when idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_favor <= 1'b0;
        end else if (w_gnt_any) begin
            r_favor <= ~w_gnt_port;
        end
    end
`endif

    // Pick the favoured port if eligible, else the other one; a favoured read
    // blocked by a full FIFO therefore lets the other port's write through.
    always_comb begin
        w_gnt_any  = 1'b0;
        w_gnt_port = 1'b0;
        if (w_elig[w_favor]) begin
            w_gnt_any  = 1'b1;
            w_gnt_port = w_favor;
        end else if (w_elig[~w_favor]) begin
            w_gnt_any  = 1'b1;
            w_gnt_port = ~w_favor;
        end
    end

    assign w_sel_we    = w_req_we[w_gnt_port];
    assign w_sel_addr  = w_req_addr[w_gnt_port];
    assign w_sel_wdata = w_req_wdata[w_gnt_port];

    assign w_push     = w_gnt_any & ~w_sel_we;
    assign w_pop      = phy_rd_valid & (r_count != '0);
    assign w_orphan   = phy_rd_valid & (r_count == '0);
    assign w_head_tag = r_tag_mem[r_rd_ptr];

    // Issue register: one cycle of phy command per grant; write data only
    // updates on writes so it holds through read commands.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_phy_wr_en  <= 1'b0;
            r_phy_rd_en  <= 1'b0;
            r_phy_addr   <= '0;
            r_phy_wr_din <= '0;
        end else begin
            r_phy_wr_en <= w_gnt_any & w_sel_we;
            r_phy_rd_en <= w_gnt_any & ~w_sel_we;
            if (w_gnt_any) begin
                r_phy_addr <= w_sel_addr;
            end
            if (w_gnt_any && w_sel_we) begin
                r_phy_wr_din <= w_sel_wdata;
            end
        end
    end

    // Tag storage: the issuing port id is written in the same edge as the read issue.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_tag_mem[r_wr_ptr] <= w_gnt_port;
        end
    end

    // Tag FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky flag for phy returns that arrive with nothing outstanding.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err_orphan <= 1'b0;
        end else if (w_orphan) begin
            r_err_orphan <= 1'b1;
        end
    end

    assign req0_ready  = w_ready[0];
    assign req1_ready  = w_ready[1];
    assign resp0_valid = r_resp_valid[0];
    assign resp0_data  = r_resp_data[0];
    assign resp1_valid = r_resp_valid[1];
    assign resp1_data  = r_resp_data[1];
    assign phy_wr_en   = r_phy_wr_en;
    assign phy_rd_en   = r_phy_rd_en;
    assign phy_addr    = r_phy_addr;
    assign phy_wr_din  = r_phy_wr_din;
    assign busy        = (r_count != '0);
    assign err_orphan  = r_err_orphan;

endmodule

// File: tb/tb_dram_arb.sv
// Testbench for dram_arb: table of per-cycle request vectors plus directed
// sequences for full FIFO, orphan returns, reset with reads in flight and
// arbitration fairness. Build with DRAM_ARB_STRICT_PRIO_EN to check fixed priority.
module tb_dram_arb;

`ifdef DRAM_ARB_STRICT_PRIO_EN
    localparam bit STRICT = 1'b1;
`else
    localparam bit STRICT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req0_valid = 1'b0, req0_we = 1'b0, req1_valid = 1'b0, req1_we = 1'b0;
    logic [21:0] req0_addr = '0, req1_addr = '0;
    logic [31:0] req0_wdata = '0, req1_wdata = '0;
    logic        req0_ready, req1_ready, resp0_valid, resp1_valid;
    logic [31:0] resp0_data, resp1_data;
    logic        phy_wr_en, phy_rd_en;
    logic [21:0] phy_addr;
    logic [31:0] phy_wr_din;
    logic [31:0] phy_rd_dout = '0;
    logic        phy_rd_valid = 1'b0;
    logic        busy, err_orphan;

    always #5 clk = ~clk;

    dram_arb #(.RAM_ADDR(22), .RAM_DWIDTH(32), .MAX_OUTST(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .resp0_valid(resp0_valid), .resp0_data(resp0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .resp1_valid(resp1_valid), .resp1_data(resp1_data),
        .phy_wr_en(phy_wr_en), .phy_rd_en(phy_rd_en), .phy_addr(phy_addr),
        .phy_wr_din(phy_wr_din), .phy_rd_dout(phy_rd_dout), .phy_rd_valid(phy_rd_valid),
        .busy(busy), .err_orphan(err_orphan)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Simple in-order phy model: returns reads one edge after it sees them,
    // or one at a time on request when auto return is off.
    logic [31:0] mem [16];
    logic [3:0]  pend [$];
    bit          auto_ret = 1'b1;
    int          rel_req = 0, rel_done = 0, inj_req = 0, inj_done = 0;

    always @(negedge clk) begin
        if (phy_wr_en) mem[phy_addr[3:0]] = phy_wr_din;
        if (phy_rd_en) pend.push_back(phy_addr[3:0]);
        if (inj_req != inj_done) begin
            phy_rd_valid = 1'b1;
            phy_rd_dout  = 32'hbad0_bad0;
            inj_done++;
        end else if (pend.size() > 0 && (auto_ret || rel_req != rel_done)) begin
            phy_rd_valid = 1'b1;
            phy_rd_dout  = mem[pend.pop_front()];
            if (!auto_ret) rel_done++;
        end else begin
            phy_rd_valid = 1'b0;
        end
    end

    // Response log, one entry per pulse.
    logic [31:0] q0 [$];
    logic [31:0] q1 [$];
    always @(negedge clk) begin
        if (resp0_valid) q0.push_back(resp0_data);
        if (resp1_valid) q1.push_back(resp1_data);
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v0, input logic w0, input logic [21:0] a0, input logic [31:0] d0,
                         input logic v1, input logic w1, input logic [21:0] a1, input logic [31:0] d1);
        req0_valid = v0; req0_we = w0; req0_addr = a0; req0_wdata = d0;
        req1_valid = v1; req1_we = w1; req1_addr = a1; req1_wdata = d1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic check_zero(input string pfx);
        chk({pfx, "_wr_en"}, phy_wr_en, 0);
        chk({pfx, "_rd_en"}, phy_rd_en, 0);
        chk({pfx, "_addr"}, phy_addr, 0);
        chk({pfx, "_din"}, phy_wr_din, 0);
        chk({pfx, "_r0v"}, resp0_valid, 0);
        chk({pfx, "_r1v"}, resp1_valid, 0);
        chk({pfx, "_r0d"}, resp0_data, 0);
        chk({pfx, "_r1d"}, resp1_data, 0);
        chk({pfx, "_busy"}, busy, 0);
        chk({pfx, "_err"}, err_orphan, 0);
        chk({pfx, "_rdy0"}, req0_ready, 0);
        chk({pfx, "_rdy1"}, req1_ready, 0);
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
    endtask

    // One cycle of stimulus: gr = expected grant in round-robin mode,
    // gs = expected grant with fixed priority (2 = no grant).
    typedef struct {
        logic v0; logic w0; logic [21:0] a0; logic [31:0] d0;
        logic v1; logic w1; logic [21:0] a1; logic [31:0] d1;
        int gr; int gs;
    } vec_t;

    localparam int NV = 18;
    vec_t        tbl [NV];
    logic [31:0] exp_mem [16];
    logic [31:0] eq0 [$];
    logic [31:0] eq1 [$];
    logic [21:0] ra [5];
    logic [31:0] rd_exp [5];

    initial begin
        int n0, n1;

        tbl[0]  = '{1, 1, 22'd1, 32'h11223344, 0, 0, 22'd0, 32'h0,        0, 0};
        tbl[1]  = '{0, 0, 22'd0, 32'h0,        1, 0, 22'd1, 32'h0,        1, 1};
        tbl[2]  = '{1, 1, 22'd2, 32'habcdef12, 1, 1, 22'd3, 32'h01234567, 0, 0};
        tbl[3]  = '{0, 0, 22'd0, 32'h0,        1, 1, 22'd3, 32'h01234567, 1, 1};
        tbl[4]  = '{1, 1, 22'd5, 32'h55555555, 1, 1, 22'd6, 32'h66666666, 0, 0};
        tbl[5]  = '{1, 1, 22'd5, 32'h55555555, 1, 1, 22'd6, 32'h66666666, 1, 0};
        tbl[6]  = '{0, 0, 22'd0, 32'h0,        1, 1, 22'd7, 32'h77777777, 1, 1};
        tbl[7]  = '{1, 1, 22'd8, 32'h88888888, 0, 0, 22'd0, 32'h0,        0, 0};
        tbl[8]  = '{0, 0, 22'd0, 32'h0,        0, 0, 22'd0, 32'h0,        2, 2};
        tbl[9]  = '{1, 1, 22'd9, 32'h99999999, 1, 1, 22'd10, 32'haaaaaaaa, 1, 0};
        for (int i = 10; i < NV; i++)
            tbl[i] = '{1, 0, 22'd2, 32'h0, 1, 0, 22'd3, 32'h0, (i % 2), 0};

        // Reset state
        idle();
        rst = 1'b0;
        repeat (2) tick();
        check_zero("rst_in");
        rst = 1'b1;
        tick();
        check_zero("rst_out");

        // Table-driven arbitration, issue and return
        for (int i = 0; i < NV; i++) begin
            int g;
            logic sw;
            logic [21:0] sa;
            logic [31:0] sd;
            g  = STRICT ? tbl[i].gs : tbl[i].gr;
            sw = 1'b0; sa = '0; sd = '0;
            if (g == 0) begin sw = tbl[i].w0; sa = tbl[i].a0; sd = tbl[i].d0; end
            if (g == 1) begin sw = tbl[i].w1; sa = tbl[i].a1; sd = tbl[i].d1; end
            drive(tbl[i].v0, tbl[i].w0, tbl[i].a0, tbl[i].d0, tbl[i].v1, tbl[i].w1, tbl[i].a1, tbl[i].d1);
            #1;
            chk($sformatf("t%0d_rdy0", i), req0_ready, (g == 0));
            chk($sformatf("t%0d_rdy1", i), req1_ready, (g == 1));
            if (g != 2 && sw) exp_mem[sa[3:0]] = sd;
            if (g == 0 && !sw) eq0.push_back(exp_mem[sa[3:0]]);
            if (g == 1 && !sw) eq1.push_back(exp_mem[sa[3:0]]);
            tick();
            chk($sformatf("t%0d_wr_en", i), phy_wr_en, (g != 2 && sw));
            chk($sformatf("t%0d_rd_en", i), phy_rd_en, (g != 2 && !sw));
            if (g != 2) chk($sformatf("t%0d_addr", i), phy_addr, sa);
            if (g != 2 && sw) chk($sformatf("t%0d_din", i), phy_wr_din, sd);
        end
        idle();
        repeat (3) tick();
        chk("tbl_q0_len", q0.size(), eq0.size());
        chk("tbl_q1_len", q1.size(), eq1.size());
        for (int k = 0; k < eq0.size() && k < q0.size(); k++) chk($sformatf("tbl_q0_%0d", k), q0[k], eq0[k]);
        for (int k = 0; k < eq1.size() && k < q1.size(); k++) chk($sformatf("tbl_q1_%0d", k), q1[k], eq1[k]);
        chk("tbl_q1_first", (q1.size() > 0) ? q1[0] : 32'hx, 32'h11223344);

        // Full FIFO: stalled phy, four reads outstanding
        do_reset();
        auto_ret = 1'b0;
        n0 = q0.size(); n1 = q1.size();
        ra     = '{22'd1, 22'd2, 22'd3, 22'd8, 22'd5};
        rd_exp = '{32'h11223344, 32'habcdef12, 32'h01234567, 32'h88888888, 32'h55555555};
        for (int k = 0; k < 4; k++) begin
            drive(1, 0, ra[k], 0, 0, 0, 0, 0);
            #1;
            chk($sformatf("full_rd%0d_rdy0", k), req0_ready, 1);
            tick();
        end
        chk("full_busy", busy, 1);
        drive(0, 0, 0, 0, 1, 1, 22'd4, 32'hdeadbeef);
        #1;
        chk("full_w1_rdy1", req1_ready, 1);
        tick();
        drive(1, 0, ra[4], 0, 1, 1, 22'd4, 32'hcafef00d);
        #1;
        chk("full_skip_rdy0", req0_ready, 0);
        chk("full_skip_rdy1", req1_ready, 1);
        tick();
        chk("full_skip_wr_en", phy_wr_en, 1);
        chk("full_skip_addr", phy_addr, 4);
        chk("full_skip_din", phy_wr_din, 32'hcafef00d);
        drive(1, 0, ra[4], 0, 0, 0, 0, 0);
        rel_req++;
        #1;
        chk("full_pop_rdy0", req0_ready, 0);
        tick();
        chk("full_after_pop_rdy0", req0_ready, 1);
        chk("full_resp0_v", resp0_valid, 1);
        chk("full_resp0_d", resp0_data, 32'h11223344);
        tick();
        chk("full_rd5_en", phy_rd_en, 1);
        idle();
        auto_ret = 1'b1;
        repeat (8) tick();
        chk("full_q0_len", q0.size() - n0, 5);
        for (int k = 0; k < 5 && (n0 + k) < q0.size(); k++)
            chk($sformatf("full_q0_%0d", k), q0[n0 + k], rd_exp[k]);
        chk("full_q1_len", q1.size() - n1, 0);
        chk("full_hold_v", resp0_valid, 0);
        chk("full_hold_d", resp0_data, 32'h55555555);
        chk("full_idle_busy", busy, 0);

        // Orphan return
        n0 = q0.size(); n1 = q1.size();
        inj_req++;
        tick();
        tick();
        chk("orph_err", err_orphan, 1);
        repeat (3) tick();
        chk("orph_err_held", err_orphan, 1);
        chk("orph_no_resp", (q0.size() - n0) + (q1.size() - n1), 0);
        do_reset();
        chk("orph_rst_clear", err_orphan, 0);

        // Reset with two reads in flight
        auto_ret = 1'b0;
        n0 = q0.size(); n1 = q1.size();
        drive(1, 0, 22'd1, 0, 1, 0, 22'd2, 0);
        tick();
        tick();
        idle();
        tick();
        chk("mid_busy", busy, 1);
        rst = 1'b0;
        #1;
        check_zero("mid_rst_now");
        tick();
        tick();
        check_zero("mid_rst_held");
        rst = 1'b1;
        auto_ret = 1'b1;
        repeat (4) tick();
        chk("mid_err", err_orphan, 1);
        chk("mid_no_resp", (q0.size() - n0) + (q1.size() - n1), 0);
        chk("mid_busy_after", busy, 0);

        // Both ports continuously valid, then port 0 drops
        do_reset();
        for (int k = 0; k < 4; k++) begin
            int g;
            g = STRICT ? 0 : (k % 2);
            drive(1, 1, 22'd11, 32'h1, 1, 1, 22'd12, 32'h2);
            #1;
            chk($sformatf("fair%0d_rdy0", k), req0_ready, (g == 0));
            chk($sformatf("fair%0d_rdy1", k), req1_ready, (g == 1));
            tick();
            chk($sformatf("fair%0d_addr", k), phy_addr, (g == 0) ? 22'd11 : 22'd12);
        end
        drive(0, 0, 0, 0, 1, 1, 22'd12, 32'h2);
        #1;
        chk("fair_drop_rdy1", req1_ready, 1);
        tick();
        chk("fair_drop_addr", phy_addr, 22'd12);
        idle();
        tick();
        chk("fair_idle_wr_en", phy_wr_en, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
